rvlab_mmcm_drp_ctrl: RTL
========================

// Module: rvlab_mmcm_drp_ctrl
// PURPOSE
//  Runtime reconfiguration sequencer for the system MMCM via its DRP port. Runs on the
//  buffered 100 MHz input clock (never an MMCM output). On start: holds MMCM in reset,
//  read-modify-writes a table of DRP registers, releases reset, waits for relock.
//  Reports busy/done/error to a bus-facing register block.
// PARAMETERS
//  N_ENTRIES     8       DRP table depth (1..16)
//  RST_HOLD      4       cycles mmcm_rst_o is held before the first DRP access
//  DRDY_TIMEOUT  64      max cycles waiting for drp_rdy_i per access
//  LOCK_TIMEOUT  100000  max cycles waiting for synchronised lock after reset release
// PORTS
//  clk_i          in   1   DRP clock (buffered 100 MHz)
//  rst_ni         in   1   async reset, active low
//  tbl_we_i       in   1   write table entry tbl_idx_i (ignored while busy_o)
//  tbl_idx_i      in   $clog2(N_ENTRIES)  entry index
//  tbl_addr_i     in   7   DRP register address
//  tbl_mask_i     in   16  1 = bit replaced by tbl_data_i, 0 = bit kept
//  tbl_data_i     in   16  new field value
//  tbl_len_i      in   $clog2(N_ENTRIES)+1  entries to apply; sampled on start
//  start_i        in   1   single-cycle start pulse
//  busy_o         out  1   sequence in progress
//  done_o         out  1   one-cycle pulse at sequence end (success or error)
//  err_o          out  2   0 ok, 1 DRDY timeout, 2 lock timeout, 3 readback mismatch
//  mmcm_rst_o     out  1   to MMCM RST
//  mmcm_locked_i  in   1   MMCM LOCKED (asynchronous; 2-FF synchronised internally)
//  drp_en_o / drp_we_o  out 1  DEN / DWE, single-cycle pulses
//  drp_addr_o     out  7   DADDR;  drp_di_o out 16 DI;  drp_do_i in 16 DO;  drp_rdy_i in 1 DRDY
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, table entries 0, err_o 0, lock sync FFs 0.
//  States: IDLE -> HOLD -> RD -> RD_WAIT -> WR -> WR_WAIT -> (RD | [VFY, VFY_WAIT] | RELEASE)
//          -> LOCK_WAIT -> DONE -> IDLE.
//  IDLE: start_i -> latch len, idx=0, err_o<=0, busy_o=1, mmcm_rst_o=1, goto HOLD.
//  HOLD: count RST_HOLD cycles; len==0 -> RELEASE, else RD.
//  RD: drp_en_o=1, drp_addr_o=tbl_addr[idx] for exactly 1 cycle.
//  RD_WAIT: on drp_rdy_i capture do; word=(do & ~mask)|(data & mask); goto WR.
//  WR: drp_en_o=drp_we_o=1, drp_di_o=word, 1 cycle. WR_WAIT: on drp_rdy_i idx++;
//      idx==len -> RELEASE else RD.
//  *_WAIT: DRDY timeout counter reset on entry; DRDY_TIMEOUT expiry -> err=1, RELEASE-on-error.
//  drp_rdy_i outside a *_WAIT state ignored; drp_addr_o/drp_di_o hold last value.
//  RELEASE: mmcm_rst_o<=0; LOCK_WAIT ignores lock for 2 cycles (sync latency), then
//    synced lock=1 -> DONE; LOCK_TIMEOUT expiry -> err=2, DONE.
//  Error path: mmcm_rst_o deasserted, remaining entries skipped, no lock wait, DONE.
//  DONE: done_o=1 one cycle, busy_o<=0, IDLE. err_o sticky until next start.
//  start_i while busy_o ignored; tbl_we_i while busy_o ignored (table stable during run).
//  Lock loss outside LOCK_WAIT not monitored by this block.
//  Latency (ideal, DRDY same cycle+1, lock immediate): 1+RST_HOLD+4*len+1+3+1 cycles.
// CONFIGURATION
//  RVLAB_MMCM_DRP_READBACK_EN defined: after WR_WAIT, VFY issues a read of the same
//   address; VFY_WAIT compares do with word; mismatch -> err=3, error path; match -> next.
//   Latency +2 cycles per entry (+DRDY wait). Not defined: VFY/VFY_WAIT absent, err 3 unused.
// TESTING
//  DRP model (DRDY 3 cycles after DEN), lock asserts 20 cycles after RST falls.
//  1 entry addr 0x08 mask 0x0FFF data 0x0041, reg=0x1000 -> write 0x1041, done_o, err 0,
//    mmcm_rst_o high from start until after the write, busy_o low after done.
//  len=3 distinct addrs -> 3 reads + 3 writes strictly in table order, DEN never overlaps.
//  len=0 -> no DEN, RST held RST_HOLD cycles, done after relock, err 0.
//  Model never raises DRDY -> err=1 after DRDY_TIMEOUT, mmcm_rst_o released, done_o pulse.
//  Lock held low -> err=2 after LOCK_TIMEOUT; next start with lock OK clears err to 0.
//  start_i and tbl_we_i mid-sequence -> ignored; rst_ni low mid-write -> all outputs 0 at
//    once; READBACK_EN with model corrupting bit 0 -> err=3.

Source files
------------

// File: rtl/rvlab_mmcm_drp_ctrl.sv
// MMCM runtime reconfiguration: holds RST, read-modify-writes a DRP table, releases RST, waits for relock.
// Define RVLAB_MMCM_DRP_READBACK_EN to re-read and compare every written register (err 3 on mismatch).
module rvlab_mmcm_drp_ctrl #(
  parameter int N_ENTRIES    = 8,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 100000,
  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
  localparam int LW = $clog2(N_ENTRIES) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tbl_we_i,
  input  logic [IW-1:0] tbl_idx_i,
  input  logic [6:0]    tbl_addr_i,
  input  logic [15:0]   tbl_mask_i,
  input  logic [15:0]   tbl_data_i,
  input  logic [LW-1:0] tbl_len_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    err_o,
  output logic          mmcm_rst_o,
  input  logic          mmcm_locked_i,
  output logic          drp_en_o,
  output logic          drp_we_o,
  output logic [6:0]    drp_addr_o,
  output logic [15:0]   drp_di_o,
  input  logic [15:0]   drp_do_i,
  input  logic          drp_rdy_i
);

  localparam int CMAX_A = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int CMAX   = (LOCK_TIMEOUT > CMAX_A) ? LOCK_TIMEOUT : CMAX_A;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef RVLAB_MMCM_DRP_READBACK_EN
  localparam logic [1:0] ERR_VFY  = 2'd3;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
`ifdef RVLAB_MMCM_DRP_READBACK_EN
    S_VFY, S_VFY_WAIT,
`endif
    S_RELEASE, S_LOCK_WAIT, S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [LW-1:0]               idx_q, idx_d, len_q, len_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [6:0]                  addr_q, addr_d;
  logic [15:0]                 di_q, di_d;
  logic [1:0]                  err_q, err_d;
  logic                        busy_q, busy_d, rst_q, rst_d;
  logic                        lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
  logic [N_ENTRIES-1:0][6:0]   tbl_addr_q, tbl_addr_d;
  logic [N_ENTRIES-1:0][15:0]  tbl_mask_q, tbl_mask_d, tbl_data_q, tbl_data_d;
  logic [IW-1:0]               cur;

  assign cur = idx_q[IW-1:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    di_d       = di_q;
    err_d      = err_q;
    busy_d     = busy_q;
    rst_d      = rst_q;
    lock_s1_d  = mmcm_locked_i;
    lock_s2_d  = lock_s1_q;
    tbl_addr_d = tbl_addr_q;
    tbl_mask_d = tbl_mask_q;
    tbl_data_d = tbl_data_q;

    // The table is frozen for the whole run so the sequence sees a consistent snapshot.
    if (tbl_we_i && !busy_q && (int'(tbl_idx_i) < N_ENTRIES)) begin
      tbl_addr_d[tbl_idx_i] = tbl_addr_i;
      tbl_mask_d[tbl_idx_i] = tbl_mask_i;
      tbl_data_d[tbl_idx_i] = tbl_data_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = (int'(tbl_len_i) > N_ENTRIES) ? LW'(N_ENTRIES) : tbl_len_i;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = ERR_OK;
          busy_d  = 1'b1;
          rst_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          state_d = (len_q == '0) ? S_RELEASE : S_RD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drp_rdy_i) begin
          di_d    = (drp_do_i & ~tbl_mask_q[cur]) | (tbl_data_q[cur] & tbl_mask_q[cur]);
          state_d = S_WR;
        end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
          err_d   = ERR_DRDY;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR: begin
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (drp_rdy_i) begin
`ifdef RVLAB_MMCM_DRP_READBACK_EN
          state_d = S_VFY;
`else
          idx_d   = idx_q + LW'(1);
          state_d = (idx_d == len_q) ? S_RELEASE : S_RD;
`endif
        end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
          err_d   = ERR_DRDY;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef RVLAB_MMCM_DRP_READBACK_EN
      S_VFY: begin
        cnt_d   = '0;
        state_d = S_VFY_WAIT;
      end
      S_VFY_WAIT: begin
        if (drp_rdy_i) begin
          if (drp_do_i != di_q) begin
            err_d   = ERR_VFY;
            state_d = S_RELEASE;
          end else begin
            idx_d   = idx_q + LW'(1);
            state_d = (idx_d == len_q) ? S_RELEASE : S_RD;
          end
        end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
          err_d   = ERR_DRDY;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_RELEASE: begin
        rst_d   = 1'b0;
        cnt_d   = '0;
        state_d = (err_q != ERR_OK) ? S_DONE : S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        // The first two cycles still show pre-reset lock through the synchroniser.
        if ((cnt_q >= CW'(2)) && lock_s2_q) begin
          state_d = S_DONE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          err_d   = ERR_LOCK;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RD && state_q != S_RD) begin
      addr_d = tbl_addr_q[idx_d[IW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      di_q       <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      rst_q      <= 1'b0;
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
      tbl_addr_q <= '0;
      tbl_mask_q <= '0;
      tbl_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      di_q       <= di_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rst_q      <= rst_d;
      lock_s1_q  <= lock_s1_d;
      lock_s2_q  <= lock_s2_d;
      tbl_addr_q <= tbl_addr_d;
      tbl_mask_q <= tbl_mask_d;
      tbl_data_q <= tbl_data_d;
    end
  end

  always_comb begin
    drp_en_o = 1'b0;
    drp_we_o = 1'b0;
    case (state_q)
      S_RD: drp_en_o = 1'b1;
      S_WR: begin
        drp_en_o = 1'b1;
        drp_we_o = 1'b1;
      end
`ifdef RVLAB_MMCM_DRP_READBACK_EN
      S_VFY: drp_en_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign done_o     = (state_q == S_DONE);
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign mmcm_rst_o = rst_q;
  assign drp_addr_o = addr_q;
  assign drp_di_o   = di_q;

endmodule
